// File: rtl/core_mmio_pkg.sv
// Shared definitions for the MMIO UART bridge: register selects (addr[3:2]),
// STATUS bit positions and the packed STATUS layout.
package core_mmio_pkg;

  localparam logic [1:0] OFS_STATUS = 2'd0;
  localparam logic [1:0] OFS_RXDATA = 2'd1;
  localparam logic [1:0] OFS_TXDATA = 2'd2;
  localparam logic [1:0] OFS_IRQEN  = 2'd3;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_NOTFULL  = 1;
  localparam int ST_TX_EMPTY    = 2;

  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [7:0] tx_count;
    logic [7:0] rx_count;
    logic [4:0] rsvd_lo;
    logic       tx_empty;
    logic       tx_notfull;
    logic       rx_nonempty;
  } status_t;

endpackage

// File: rtl/mmio_sync_fifo.sv
// Single-clock FIFO with power-of-2 depth and an occupancy count.
// The caller guarantees push is legal, i.e. not full unless it pops in the same cycle.
module mmio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next pointer and count; pointers wrap naturally at the power-of-2 depth.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (i_push) begin
      wptr_d = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (i_pop) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    count_d = count_q + CW'(i_push) - CW'(i_pop);
  end

  // Pointer, count and storage registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (i_push) mem_q[wptr_q] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[rptr_q];
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == CW'(0));
  assign o_count = count_q;

endmodule

// File: rtl/core_mmio_uart_bridge.sv
// MMIO bridge between the core data port and a byte UART: STATUS/RXDATA/TXDATA window
// with TX/RX FIFOs. Define CORE_MMIO_UART_IRQ_EN to add the IRQ_EN register and o_irq.
module core_mmio_uart_bridge
  import core_mmio_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MMIO_BASE = 32'h8000_0000,
  parameter int              TX_DEPTH  = 4,
  parameter int              RX_DEPTH  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  input  logic            i_req_write,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_hit,
  output logic            o_stall,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_rdata_valid,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_valid,
  input  logic            i_tx_ready,
  input  logic [7:0]      i_rx_data,
  input  logic            i_rx_valid,
  output logic            o_rx_ready
`ifdef CORE_MMIO_UART_IRQ_EN
  ,
  output logic            o_irq
`endif
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic             hit_s, rd_s, wr_s, tx_push_req_s, tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic [1:0]       reg_sel_s;
  logic             tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic [TX_CW-1:0] tx_count_s;
  logic [RX_CW-1:0] rx_count_s;
  logic [7:0]       rx_head_s;
  status_t          status_s;
  logic [XLEN-1:0]  rd_mux_s, rdata_d, rdata_q;
  logic             rdata_valid_d, rdata_valid_q;
  logic             unused_s;

  assign unused_s  = ^{i_req_wdata[XLEN-1:8], i_req_addr[1:0]};
  assign hit_s     = i_req_valid & (i_req_addr[XLEN-1:4] == MMIO_BASE[XLEN-1:4]);
  assign reg_sel_s = i_req_addr[3:2];
  assign rd_s      = hit_s & ~i_req_write;
  assign wr_s      = hit_s & i_req_write;

  // Stall uses only the registered full flag, so a same-cycle drain cannot release it.
  assign tx_push_req_s = wr_s & (reg_sel_s == OFS_TXDATA);
  assign tx_push_s     = tx_push_req_s & ~tx_full_s;
  assign tx_pop_s      = ~tx_empty_s & i_tx_ready;
  assign rx_pop_s      = rd_s & (reg_sel_s == OFS_RXDATA) & ~rx_empty_s;
  // A full RX FIFO still takes a UART byte when RXDATA frees a slot in the same cycle.
  assign rx_push_s     = i_rx_valid & (~rx_full_s | rx_pop_s);

  mmio_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (tx_push_s),
    .i_wdata (i_req_wdata[7:0]),
    .i_pop   (tx_pop_s),
    .o_rdata (o_tx_data),
    .o_full  (tx_full_s),
    .o_empty (tx_empty_s),
    .o_count (tx_count_s)
  );

  mmio_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (rx_push_s),
    .i_wdata (i_rx_data),
    .i_pop   (rx_pop_s),
    .o_rdata (rx_head_s),
    .o_full  (rx_full_s),
    .o_empty (rx_empty_s),
    .o_count (rx_count_s)
  );

`ifdef CORE_MMIO_UART_IRQ_EN
  logic [1:0] irq_en_d, irq_en_q;
  logic       irq_d, irq_q;

  // IRQ_EN write and interrupt level from the current FIFO state.
  always_comb begin
    if (wr_s && (reg_sel_s == OFS_IRQEN)) begin
      irq_en_d = i_req_wdata[1:0];
    end else begin
      irq_en_d = irq_en_q;
    end
    irq_d = (irq_en_q[0] & ~rx_empty_s) | (irq_en_q[1] & tx_empty_s);
  end

  // IRQ registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_en_q <= 2'b00;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign o_irq = irq_q;
`endif

  // STATUS assembly and read mux, sampled before any RXDATA pop.
  always_comb begin
    status_s             = '0;
    status_s.rx_nonempty = ~rx_empty_s;
    status_s.tx_notfull  = ~tx_full_s;
    status_s.tx_empty    = tx_empty_s;
    status_s.rx_count    = 8'(rx_count_s);
    status_s.tx_count    = 8'(tx_count_s);
    rd_mux_s             = '0;
    case (reg_sel_s)
      OFS_STATUS: rd_mux_s = XLEN'(status_s);
      OFS_RXDATA: begin
        if (!rx_empty_s) begin
          rd_mux_s = XLEN'({1'b1, rx_head_s});
        end else begin
          rd_mux_s = '0;
        end
      end
      OFS_TXDATA: rd_mux_s = '0;
`ifdef CORE_MMIO_UART_IRQ_EN
      OFS_IRQEN:  rd_mux_s = XLEN'(irq_en_q);
`else
      OFS_IRQEN:  rd_mux_s = '0;
`endif
      default:    rd_mux_s = '0;
    endcase
    if (rd_s) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = '0;
    end
    rdata_valid_d = rd_s;
  end

  // Read-data registers, one-cycle latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign o_hit         = hit_s;
  assign o_stall       = tx_push_req_s & tx_full_s;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rdata_valid_q;
  assign o_tx_valid    = ~tx_empty_s;
  assign o_rx_ready    = ~rx_full_s;

endmodule

// File: tb/tb_core_mmio_uart_bridge.sv
// Scoreboard bench for core_mmio_uart_bridge: expected reads and TX bytes are queued
// as stimulus is driven and compared when the bridge produces them.
module tb_core_mmio_uart_bridge;

  logic        clk, rst_n;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        hit, stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
`ifdef CORE_MMIO_UART_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];

  core_mmio_uart_bridge dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (req_valid),
    .i_req_write   (req_write),
    .i_req_addr    (req_addr),
    .i_req_wdata   (req_wdata),
    .o_hit         (hit),
    .o_stall       (stall),
    .o_rdata       (rdata),
    .o_rdata_valid (rdata_valid),
    .o_tx_data     (tx_data),
    .o_tx_valid    (tx_valid),
    .i_tx_ready    (tx_ready),
    .i_rx_data     (rx_data),
    .i_rx_valid    (rx_valid),
    .o_rx_ready    (rx_ready)
`ifdef CORE_MMIO_UART_IRQ_EN
    ,
    .o_irq         (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
  endtask

  task automatic mmio_read(input logic [31:0] addr, input logic [31:0] exp);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    #1;
    check("rd_hit", {31'd0, hit}, 32'd1);
    rd_q.push_back(exp);
    cyc();
    idle_req();
  endtask

  task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    #1;
    check("wr_stall", {31'd0, stall}, 32'd0);
    cyc();
    idle_req();
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    cyc();
    rx_valid = 1'b0;
  endtask

  // Read-data and TX-byte scoreboards, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && rdata_valid) begin
      if (rd_q.size() == 0) check("rd_spurious", 32'd1, 32'd0);
      else check("rdata", rdata, rd_q.pop_front());
    end
    if (rst_n && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) check("tx_spurious", {24'd0, tx_data}, 32'hFFFF_FFFF);
      else check("tx_byte", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle_req();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    cyc();
    mmio_read(32'h8000_0000, 32'h0000_0006);

    // TX fill to full with no drain, then a stalled fifth store
    for (int i = 0; i < 4; i++) begin
      tx_q.push_back(8'h41 + 8'(i));
      mmio_write(32'h8000_0008, 32'h0000_0041 + 32'(i));
    end
    mmio_read(32'h8000_0000, 32'h0004_0000);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h8000_0008;
    req_wdata = 32'hFFFF_FF45;
    #1;
    check("stall_full", {31'd0, stall}, 32'd1);
    cyc();
    check("stall_hold", {31'd0, stall}, 32'd1);
    tx_ready = 1'b1;
    #1;
    check("stall_same_cycle_drain", {31'd0, stall}, 32'd1);
    cyc();
    check("stall_release", {31'd0, stall}, 32'd0);
    tx_q.push_back(8'h45);
    cyc();
    idle_req();
    for (int t = 0; t < 50 && tx_valid; t++) cyc();
    check("tx_drained", {31'd0, tx_valid}, 32'd0);
    check("tx_q_empty", 32'(tx_q.size()), 32'd0);
    tx_ready = 1'b0;

    // RX bytes read back in order, then empty read
    check("rx_ready_empty", {31'd0, rx_ready}, 32'd1);
    rx_send(8'h5A);
    rx_send(8'hA5);
    mmio_read(32'h8000_0000, 32'h0000_0207);
    mmio_read(32'h8000_0004, 32'h0000_015A);
    mmio_read(32'h8000_0004, 32'h0000_01A5);
    mmio_read(32'h8000_0004, 32'h0000_0000);

    // RX full with simultaneous UART push and RXDATA pop
    rx_send(8'h11);
    rx_send(8'h22);
    rx_send(8'h33);
    rx_send(8'h44);
    check("rx_ready_full", {31'd0, rx_ready}, 32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    mmio_read(32'h8000_0004, 32'h0000_0111);
    rx_valid = 1'b0;
    check("rx_ready_still_full", {31'd0, rx_ready}, 32'd0);
    mmio_read(32'h8000_0000, 32'h0000_0407);
    mmio_read(32'h8000_0004, 32'h0000_0122);
    mmio_read(32'h8000_0004, 32'h0000_0133);
    mmio_read(32'h8000_0004, 32'h0000_0144);
    mmio_read(32'h8000_0004, 32'h0000_0177);

    // Out-of-window accesses and ignored registers
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h8000_0010;
    req_wdata = 32'h0000_0099;
    #1;
    check("miss_hi_hit", {31'd0, hit}, 32'd0);
    check("miss_hi_stall", {31'd0, stall}, 32'd0);
    cyc();
    req_write = 1'b0;
    req_addr  = 32'h7FFF_FFFC;
    #1;
    check("miss_lo_hit", {31'd0, hit}, 32'd0);
    cyc();
    idle_req();
    check("miss_no_tx", {31'd0, tx_valid}, 32'd0);
    mmio_write(32'h8000_0000, 32'h0000_00FF);
    mmio_write(32'h8000_0004, 32'h0000_00FF);
    mmio_read(32'h8000_0000, 32'h0000_0006);
    mmio_read(32'h8000_000B, 32'h0000_0000);
`ifdef CORE_MMIO_UART_IRQ_EN
    check("irq_idle", {31'd0, irq}, 32'd0);
    mmio_write(32'h8000_000C, 32'h0000_0001);
    mmio_read(32'h8000_000C, 32'h0000_0001);
    rx_send(8'h3C);
    check("irq_push_edge", {31'd0, irq}, 32'd0);
    cyc();
    check("irq_set", {31'd0, irq}, 32'd1);
    mmio_read(32'h8000_0004, 32'h0000_013C);
    check("irq_pop_edge", {31'd0, irq}, 32'd1);
    cyc();
    check("irq_clear", {31'd0, irq}, 32'd0);
`else
    mmio_write(32'h8000_000C, 32'h0000_0003);
    mmio_read(32'h8000_000C, 32'h0000_0000);
`endif
    cyc();
    cyc();
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
